// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the processing-element blocks (pe_lram_loader and
// pe_con): default data width, default local-RAM depth, and the loader's
// FSM state type.
// ---------------------------------------------------------------------------
package pe_pkg;

  // Defaults shared by the loader and pe_con so both ends agree on geometry.
  localparam int PE_VECTOR_SIZE = 32;
  localparam int PE_L_RAM_SIZE  = 4;

  // LOAD : accepting stream words into the local RAM
  // FIRE : single cycle that pulses start towards pe_con
  // RUN  : pe_con owns the RAM contents, wait for done
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    RUN  = 2'd2
  } lram_state_t;

endpackage

// File: rtl/pe_lram_bram.sv
// ---------------------------------------------------------------------------
// pe_lram_bram
// Simple dual-port RAM: one write port, one registered read-first read port.
// Written so that synthesis maps it onto block RAM.
//
// Ports:
//   i_clk      clock, all logic on posedge
//   i_rst_n    synchronous active-low reset of the read-data register only
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address, sampled every cycle
//   o_rd_data  read data, valid one cycle after i_rd_addr
// ---------------------------------------------------------------------------
module pe_lram_bram
  import pe_pkg::*;
#(
  parameter int VECTOR_SIZE = PE_VECTOR_SIZE,
  parameter int L_RAM_SIZE  = PE_L_RAM_SIZE
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [L_RAM_SIZE-1:0]  i_wr_addr,
  input  logic [VECTOR_SIZE-1:0] i_wr_data,
  input  logic [L_RAM_SIZE-1:0]  i_rd_addr,
  output logic [VECTOR_SIZE-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** L_RAM_SIZE;

  logic [VECTOR_SIZE-1:0] r_mem [DEPTH];
  logic [VECTOR_SIZE-1:0] r_rd_data;

  // NOTE: the storage array has no reset; resetting it would prevent
  // block-RAM inference and turn it into a large bank of flops.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // NOTE: non-blocking assignments on both ports make a same-address
  // read/write return the old word (read-first) without any bypass logic.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pe_lram_loader.sv
// ---------------------------------------------------------------------------
// pe_lram_loader
// Fills the PE local RAM from a valid/ready word stream. After a full frame
// of 2**L_RAM_SIZE words it pulses start, serves pe_con's read port while
// pe_con runs, and waits for done before accepting the next frame.
//
// Ports:
//   aclk        clock, all logic on posedge
//   aresetn     synchronous active-low reset
//   s_tvalid    stream word valid
//   s_tready    stream ready (function of state only)
//   s_tdata     stream word
//   s_tlast     last word of frame marker
//   rdaddr      read address from pe_con
//   rddata      registered read data (1-cycle latency, read-first)
//   start       one-cycle pulse: RAM loaded, pe_con may begin
//   done        pe_con finished; RAM may be reloaded
//   busy        high in FIRE and RUN
//   fill_level  words written in the current frame
//   err_len     sticky framing error
// ---------------------------------------------------------------------------
module pe_lram_loader
  import pe_pkg::*;
#(
  parameter int VECTOR_SIZE = PE_VECTOR_SIZE,
  parameter int L_RAM_SIZE  = PE_L_RAM_SIZE
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [VECTOR_SIZE-1:0] s_tdata,
  input  logic                   s_tlast,
  input  logic [L_RAM_SIZE-1:0]  rdaddr,
  output logic [VECTOR_SIZE-1:0] rddata,
  output logic                   start,
  input  logic                   done,
  output logic                   busy,
  output logic [L_RAM_SIZE:0]    fill_level,
  output logic                   err_len
);

  localparam int                  DEPTH      = 2 ** L_RAM_SIZE;
  localparam logic [L_RAM_SIZE-1:0] LAST_ADDR  = L_RAM_SIZE'(DEPTH - 1);
  localparam logic [L_RAM_SIZE:0]   FULL_LEVEL = (L_RAM_SIZE + 1)'(DEPTH);

  lram_state_t             r_state;
  logic [L_RAM_SIZE-1:0]   r_wr_ptr;
  logic [L_RAM_SIZE:0]     r_fill;
  logic                    r_start;
  logic                    r_busy;
  logic                    r_tready;
  logic                    r_err;

  logic w_beat;
  logic w_wr_en;
  logic w_final;

  // r_tready is only ever high in LOAD, so a handshake implies LOAD.
  assign w_beat  = s_tvalid & r_tready;
  // A beat presented during the reset cycle must not disturb the RAM.
  assign w_wr_en = w_beat & aresetn;
  assign w_final = (r_wr_ptr == LAST_ADDR);

  // Outputs are registered alongside the state so each one is a pure
  // function of the current state and no input reaches them combinationally.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= LOAD;
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_tready <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_beat) begin
            if (w_final) begin
              // Full frame: used even without tlast, but flagged.
              r_state  <= FIRE;
              r_wr_ptr <= '0;
              r_fill   <= FULL_LEVEL;
              r_start  <= 1'b1;
              r_busy   <= 1'b1;
              r_tready <= 1'b0;
              r_err    <= ~s_tlast;
            end else if (s_tlast) begin
              // Short frame: word is written, the frame is dropped.
              r_wr_ptr <= '0;
              r_fill   <= '0;
              r_err    <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + L_RAM_SIZE'(1);
              r_fill   <= r_fill + (L_RAM_SIZE + 1)'(1);
            end
          end
        end

        FIRE: begin
          r_state <= RUN;
          r_start <= 1'b0;
        end

        RUN: begin
          if (done) begin
            r_state  <= LOAD;
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_busy   <= 1'b0;
            r_tready <= 1'b1;
          end
        end

        default: begin
          r_state  <= LOAD;
          r_wr_ptr <= '0;
          r_fill   <= '0;
          r_start  <= 1'b0;
          r_busy   <= 1'b0;
          r_tready <= 1'b1;
        end
      endcase
    end
  end

  pe_lram_bram #(
    .VECTOR_SIZE (VECTOR_SIZE),
    .L_RAM_SIZE  (L_RAM_SIZE)
  ) u_bram (
    .i_clk     (aclk),
    .i_rst_n   (aresetn),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (s_tdata),
    .i_rd_addr (rdaddr),
    .o_rd_data (rddata)
  );

  assign s_tready   = r_tready;
  assign start      = r_start;
  assign busy       = r_busy;
  assign fill_level = r_fill;
  assign err_len    = r_err;

endmodule

// File: tb/tb_pe_lram_loader.sv
// ---------------------------------------------------------------------------
// tb_pe_lram_loader
// Self-checking bench: directed frames with literal expectations, then a
// randomized phase. A frame-level model (word counter, busy flag with an
// age counter, array copy of the RAM) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_pe_lram_loader;
  import pe_pkg::*;

  localparam int V     = 32;
  localparam int L     = 4;
  localparam int DEPTH = 16;

  logic          aclk     = 1'b0;
  logic          aresetn  = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast  = 1'b0;
  logic          done     = 1'b0;
  logic [V-1:0]  s_tdata  = '0;
  logic [L-1:0]  rdaddr   = '0;
  logic          s_tready;
  logic [V-1:0]  rddata;
  logic          start;
  logic          busy;
  logic [L:0]    fill_level;
  logic          err_len;

  always #5 aclk = ~aclk;

  pe_lram_loader #(.VECTOR_SIZE(V), .L_RAM_SIZE(L)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .rdaddr     (rdaddr),
    .rddata     (rddata),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .fill_level (fill_level),
    .err_len    (err_len)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [V-1:0] m_mem  [DEPTH];
  bit           m_memv [DEPTH];
  int           m_words = 0;   // words collected in the frame being loaded
  bit           m_busy  = 0;   // frame handed to pe_con
  int           m_age   = 0;   // cycles since the frame was handed over
  bit           m_err   = 0;
  logic [V-1:0] m_rd    = '0;
  bit           m_rdv   = 0;
  bit           m_armed = 0;
  int           n_start = 0;

  always @(posedge aclk) begin
    if (!aresetn) begin
      m_words = 0;
      m_busy  = 0;
      m_age   = 0;
      m_err   = 0;
      m_rd    = '0;
      m_rdv   = 1;
      m_armed = 1;
    end else begin
      m_rd  = m_mem[rdaddr];
      m_rdv = m_memv[rdaddr];
      if (!m_busy) begin
        if (s_tvalid) begin
          m_mem[m_words]  = s_tdata;
          m_memv[m_words] = 1;
          m_words++;
          if (m_words == DEPTH) begin
            m_busy  = 1;
            m_age   = 0;
            m_err   = !s_tlast;
            m_words = 0;
          end else if (s_tlast) begin
            m_err   = 1;
            m_words = 0;
          end
        end
      end else if (m_age > 0 && done) begin
        m_busy  = 0;
        m_words = 0;
      end else begin
        m_age++;
      end
    end
  end

  always @(negedge aclk) begin
    if (m_armed) begin
      check("start",      64'(start),      64'(m_busy && m_age == 0));
      check("busy",       64'(busy),       64'(m_busy));
      check("s_tready",   64'(s_tready),   64'(!m_busy));
      check("fill_level", 64'(fill_level), 64'(m_busy ? DEPTH : m_words));
      check("err_len",    64'(err_len),    64'(m_err));
      if (m_rdv) check("rddata", 64'(rddata), 64'(m_rd));
      if (start) n_start++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_word(input logic [V-1:0] d, input bit last);
    int guard;
    guard    = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    while (!s_tready && guard < 100) begin
      tick();
      guard++;
    end
    check("tready_wait", 64'(s_tready), 64'(1));
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [V-1:0] base, input int n, input bit last_flag,
                            input int max_gap);
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      send_word(base + V'(i), last_flag && (i == n - 1));
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int s0;
    repeat (2) tick();
    aresetn = 1'b1;
    check("rst_tready", 64'(s_tready), 64'(1));
    check("rst_busy",   64'(busy),     64'(0));
    check("rst_fill",   64'(fill_level), 64'(0));
    check("rst_rddata", 64'(rddata),   64'(0));

    // Frame 1: 0..15, tlast on the 16th, continuous valid.
    s0 = n_start;
    send_frame('0, 16, 1, 0);
    check("f1_start", 64'(start),      64'(1));
    check("f1_busy",  64'(busy),       64'(1));
    check("f1_err",   64'(err_len),    64'(0));
    check("f1_fill",  64'(fill_level), 64'(16));
    tick();
    check("f1_start_gone", 64'(start), 64'(0));

    // Readback in RUN while the stream pushes DEADBEEF against back-pressure.
    s_tvalid = 1'b1;
    s_tdata  = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) begin
      rdaddr = L'(i);
      tick();
      check("run_rd", 64'(rddata), 64'(i));
      check("run_tready", 64'(s_tready), 64'(0));
    end
    rdaddr = '0;
    tick();
    check("run_no_write", 64'(rddata), 64'(0));
    s_tvalid = 1'b0;
    check("f1_one_start", 64'(n_start - s0), 64'(1));

    pulse_done();
    check("done_tready", 64'(s_tready), 64'(1));
    check("done_busy",   64'(busy),     64'(0));

    // Frame 2: 0x3F800000+i.
    send_frame(32'h3F800000, 16, 1, 0);
    check("f2_start", 64'(start), 64'(1));
    rdaddr = 4'd5;
    tick();
    check("f2_rd5", 64'(rddata), 64'(32'h3F800005));
    pulse_done();

    // Short frame: 6 words, tlast on the 6th.
    s0 = n_start;
    send_frame(32'hA0, 6, 1, 0);
    check("short_err",  64'(err_len),    64'(1));
    check("short_fill", 64'(fill_level), 64'(0));
    check("short_busy", 64'(busy),       64'(0));
    repeat (3) tick();
    check("short_no_start", 64'(n_start - s0), 64'(0));

    // Clean frame clears the error.
    send_frame(32'h100, 16, 1, 0);
    check("clean_start", 64'(start),   64'(1));
    check("clean_err",   64'(err_len), 64'(0));
    tick();
    pulse_done();

    // Gapped frame, no tlast on the final beat.
    send_frame(32'h200, 16, 0, 3);
    check("gap_start", 64'(start),      64'(1));
    check("gap_err",   64'(err_len),    64'(1));
    check("gap_fill",  64'(fill_level), 64'(16));
    repeat (3) tick();

    // Reset in RUN.
    aresetn = 1'b0;
    tick();
    check("mid_rst_busy",   64'(busy),       64'(0));
    check("mid_rst_start",  64'(start),      64'(0));
    check("mid_rst_rddata", 64'(rddata),     64'(0));
    check("mid_rst_fill",   64'(fill_level), 64'(0));
    aresetn = 1'b1;
    check("mid_rst_tready", 64'(s_tready), 64'(1));
    pulse_done();
    check("late_done_busy",   64'(busy),     64'(0));
    check("late_done_tready", 64'(s_tready), 64'(1));

    // Randomized phase; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      s_tvalid = 1'($urandom_range(0, 3) != 0);
      s_tdata  = $urandom;
      s_tlast  = 1'($urandom_range(0, 11) == 0);
      rdaddr   = L'($urandom_range(0, DEPTH - 1));
      done     = 1'($urandom_range(0, 5) == 0);
      aresetn  = 1'($urandom_range(0, 299) != 0);
      tick();
    end
    s_tvalid = 1'b0;
    done     = 1'b0;
    aresetn  = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
